seq_mul: RTL and testbench

Sequential shift-and-add unsigned multiplier. Multiplies two WIDTH-bit operands over WIDTH clock cycles. Returns a 2*WIDTH-bit product on a registered output that holds its value until the next product completes. Small arithmetic leaf block. The controller issues a one-cycle start pulse and reads op once done is asserted.

---
 rtl/seq_mul_pkg.sv | 14 +
 rtl/seq_mul_dp.sv | 55 +++++
 rtl/seq_mul.sv | 99 +++++++++
 tb/tb_seq_mul.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/seq_mul_pkg.sv
// seq_mul_pkg: shared types and constants for the seq_mul shift-and-add multiplier.
// Optional build macro SEQ_MUL_EARLY_TERM_EN is consumed by seq_mul_dp.
package seq_mul_pkg;

   // Default operand width; the product is twice this wide.
   localparam int DEFAULT_WIDTH = 4;

   // Controller states: waiting for start, or iterating over multiplier bits.
   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

endpackage : seq_mul_pkg

// File: rtl/seq_mul_dp.sv
// seq_mul_dp: datapath for seq_mul. Holds the shifted multiplicand, the
// shifted multiplier and the running accumulator, plus the add stage.
// Optional build macro SEQ_MUL_EARLY_TERM_EN: when defined, early_last flags
// the iteration after which no multiplier bits remain set.
module seq_mul_dp
   import seq_mul_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 load,
   input  logic                 step,
   input  logic [WIDTH-1:0]     a,
   input  logic [WIDTH-1:0]     b,
   output logic [2*WIDTH-1:0]   acc_next,
   output logic                 early_last
);

   logic [2*WIDTH-1:0] mcand;
   logic [WIDTH-1:0]   mplier;
   logic [2*WIDTH-1:0] acc;

   // Add the multiplicand into the accumulator when the current multiplier bit is set.
   always_comb begin
      acc_next = acc + (mplier[0] ? mcand : '0);
   end

`ifdef SEQ_MUL_EARLY_TERM_EN
   // Final iteration once the remaining multiplier bits, after this shift, are all zero.
   assign early_last = ((mplier >> 1) == '0);
`else
   assign early_last = 1'b0;
`endif

   // Load operands on start, then shift one bit position per RUN cycle.
   always_ff @(posedge clk) begin
      // NOTE: non-blocking assignments so every register samples pre-edge values,
      // which keeps acc, mcand and mplier in lockstep within one iteration.
      if (!rst_n) begin
         mcand  <= '0;
         mplier <= '0;
         acc    <= '0;
      end else if (load) begin
         mcand  <= {{WIDTH{1'b0}}, a};
         mplier <= b;
         acc    <= '0;
      end else if (step) begin
         acc    <= acc_next;
         mcand  <= mcand << 1;
         mplier <= mplier >> 1;
      end
   end

endmodule : seq_mul_dp

// File: rtl/seq_mul.sv
// seq_mul: sequential shift-and-add unsigned multiplier (top level).
// One start pulse launches a WIDTH-cycle multiply; op holds the last product
// and done pulses for one cycle when a new product lands.
// Optional build macro SEQ_MUL_EARLY_TERM_EN: finish as soon as the remaining
// multiplier bits are zero (latency = max(1, msb(b)+1)).
module seq_mul
   import seq_mul_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start,
   input  logic [WIDTH-1:0]     a,
   input  logic [WIDTH-1:0]     b,
   output logic [2*WIDTH-1:0]   op,
   output logic                 busy,
   output logic                 done
);

   localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   count_q;
   logic [2*WIDTH-1:0] op_q;
   logic               done_q;
   logic               load, step, finish;
   logic [2*WIDTH-1:0] acc_next;
   logic               early_last;

   seq_mul_dp #(
      .WIDTH (WIDTH)
   ) u_dp (
      .clk        (clk),
      .rst_n      (rst_n),
      .load       (load),
      .step       (step),
      .a          (a),
      .b          (b),
      .acc_next   (acc_next),
      .early_last (early_last)
   );

   // State register.
   always_ff @(posedge clk) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   // Next-state and control decode; starts in RUN are ignored.
   always_comb begin
      // NOTE: every output of this block gets a default first so no path
      // leaves one unassigned, which would otherwise infer a latch.
      state_d = state_q;
      load    = 1'b0;
      step    = 1'b0;
      finish  = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) begin
               load    = 1'b1;
               state_d = RUN;
            end
         end
         RUN: begin
            step = 1'b1;
            if (count_q == LAST_CNT || early_last) begin
               finish  = 1'b1;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Iteration counter: cleared on load, advanced every RUN cycle.
   always_ff @(posedge clk) begin
      if (!rst_n)    count_q <= '0;
      else if (load) count_q <= '0;
      else if (step) count_q <= count_q + 1'b1;
   end

   // Result register and done pulse; op holds until the next product completes.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         op_q   <= '0;
         done_q <= 1'b0;
      end else begin
         done_q <= finish;
         if (finish) op_q <= acc_next;
      end
   end

   assign op   = op_q;
   assign done = done_q;
   assign busy = (state_q == RUN);

endmodule : seq_mul

// File: tb/tb_seq_mul.sv
// tb_seq_mul: directed self-checking bench for seq_mul (WIDTH = 4).
// Honours SEQ_MUL_EARLY_TERM_EN for the expected latency.
module tb_seq_mul;

   localparam int W = 4;

   logic           clk = 1'b0;
   logic           rst_n = 1'b0;
   logic           start = 1'b0;
   logic [W-1:0]   a = '0;
   logic [W-1:0]   b = '0;
   logic [2*W-1:0] op;
   logic           busy;
   logic           done;

   int pass_cnt  = 0;
   int total_cnt = 0;

   seq_mul #(.WIDTH(W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start),
      .a     (a),
      .b     (b),
      .op    (op),
      .busy  (busy),
      .done  (done)
   );

   always #5 clk = ~clk;

   // Expected latency in cycles from the start-sampling edge to done.
   function automatic int exp_lat(input logic [W-1:0] bv);
`ifdef SEQ_MUL_EARLY_TERM_EN
      int m;
      m = 1;
      for (int i = 0; i < W; i++) if (bv[i]) m = i + 1;
      return m;
`else
      return W;
`endif
   endfunction

   // Pulse start (called at a negedge), wait for done; returns at the negedge
   // where done is high. lat = -1 on timeout.
   task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tbv,
                         output int lat, output int busy_cyc,
                         output logic [2*W-1:0] op_first);
      a = ta; b = tbv; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      op_first = op;
      lat = 0;
      busy_cyc = 0;
      while (!done && lat < 20) begin
         if (busy) busy_cyc++;
         @(negedge clk);
         lat++;
      end
      if (!done) lat = -1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      total_cnt++;
      if (op !== 8'd0) $display("FAIL reset_op: got %0d expected 0", op); else pass_cnt++;
      total_cnt++;
      if (busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", busy); else pass_cnt++;
      total_cnt++;
      if (done !== 1'b0) $display("FAIL reset_done: got %b expected 0", done); else pass_cnt++;
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_basic();
      int lat, bc;
      logic [2*W-1:0] of;
      run_op(4'd3, 4'd5, lat, bc, of);
      total_cnt++;
      if (lat !== exp_lat(4'd5)) $display("FAIL basic_latency: got %0d expected %0d", lat, exp_lat(4'd5)); else pass_cnt++;
      total_cnt++;
      if (bc !== exp_lat(4'd5)) $display("FAIL basic_busy_cycles: got %0d expected %0d", bc, exp_lat(4'd5)); else pass_cnt++;
      total_cnt++;
      if (op !== 8'd15) $display("FAIL basic_op: got %0d expected 15", op); else pass_cnt++;
      total_cnt++;
      if (busy !== 1'b0) $display("FAIL basic_busy_at_done: got %b expected 0", busy); else pass_cnt++;
      @(negedge clk);
      total_cnt++;
      if (done !== 1'b0) $display("FAIL basic_done_one_cycle: got %b expected 0", done); else pass_cnt++;
      total_cnt++;
      if (op !== 8'd15) $display("FAIL basic_op_held: got %0d expected 15", op); else pass_cnt++;
   endtask

   task automatic test_back_to_back();
      int lat, bc;
      logic [2*W-1:0] of;
      run_op(4'd9, 4'd2, lat, bc, of);
      total_cnt++;
      if (of !== 8'd15) $display("FAIL b2b_op_not_cleared: got %0d expected 15", of); else pass_cnt++;
      total_cnt++;
      if (lat !== exp_lat(4'd2)) $display("FAIL b2b_lat_18: got %0d expected %0d", lat, exp_lat(4'd2)); else pass_cnt++;
      total_cnt++;
      if (op !== 8'd18) $display("FAIL b2b_op_18: got %0d expected 18", op); else pass_cnt++;
      @(negedge clk);
      run_op(4'd7, 4'd7, lat, bc, of);
      total_cnt++;
      if (of !== 8'd18) $display("FAIL b2b_op_held_18: got %0d expected 18", of); else pass_cnt++;
      total_cnt++;
      if (op !== 8'd49) $display("FAIL b2b_op_49: got %0d expected 49", op); else pass_cnt++;
      @(negedge clk);
   endtask

   task automatic test_extremes();
      int lat, bc;
      logic [2*W-1:0] of;
      run_op(4'd15, 4'd15, lat, bc, of);
      total_cnt++;
      if (op !== 8'd225) $display("FAIL max_op: got %0d expected 225", op); else pass_cnt++;
      @(negedge clk);
      run_op(4'd0, 4'd9, lat, bc, of);
      total_cnt++;
      if (lat !== exp_lat(4'd9)) $display("FAIL zero_a_latency: got %0d expected %0d", lat, exp_lat(4'd9)); else pass_cnt++;
      total_cnt++;
      if (op !== 8'd0) $display("FAIL zero_a_op: got %0d expected 0", op); else pass_cnt++;
      @(negedge clk);
   endtask

   task automatic test_start_mid_run();
      int lat;
      a = 4'd6; b = 4'd7; start = 1'b1;
      @(negedge clk);                 // E0 sampled 6*7
      a = 4'd1; b = 4'd1;             // start still high during RUN
      @(negedge clk);
      start = 1'b0;
      a = 4'd2; b = 4'd2;
      lat = 1;
      while (!done && lat < 20) begin
         @(negedge clk);
         lat++;
      end
      total_cnt++;
      if (lat !== exp_lat(4'd7)) $display("FAIL mid_run_latency: got %0d expected %0d", lat, exp_lat(4'd7)); else pass_cnt++;
      total_cnt++;
      if (op !== 8'd42) $display("FAIL mid_run_op: got %0d expected 42", op); else pass_cnt++;
      @(negedge clk);
   endtask

   task automatic test_start_in_done_cycle();
      int lat, bc;
      logic [2*W-1:0] of;
      run_op(4'd2, 4'd6, lat, bc, of);
      total_cnt++;
      if (op !== 8'd12) $display("FAIL done_cycle_first_op: got %0d expected 12", op); else pass_cnt++;
      // Still in the done cycle: this start must be accepted.
      run_op(4'd5, 4'd3, lat, bc, of);
      total_cnt++;
      if (lat !== exp_lat(4'd3)) $display("FAIL done_cycle_latency: got %0d expected %0d", lat, exp_lat(4'd3)); else pass_cnt++;
      total_cnt++;
      if (op !== 8'd15) $display("FAIL done_cycle_op: got %0d expected 15", op); else pass_cnt++;
      @(negedge clk);
   endtask

   task automatic test_continuous_start();
      int L, dones;
      L = exp_lat(4'd3);
      a = 4'd3; b = 4'd3; start = 1'b1;
      dones = 0;
      for (int i = 0; i < 2 * L + 3; i++) begin
         @(negedge clk);
         if (done) dones++;
      end
      start = 1'b0;
      total_cnt++;
      if (dones !== 2) $display("FAIL held_start_dones: got %0d expected 2", dones); else pass_cnt++;
      total_cnt++;
      if (op !== 8'd9) $display("FAIL held_start_op: got %0d expected 9", op); else pass_cnt++;
      repeat (W + 2) @(negedge clk);
   endtask

   task automatic test_reset_mid_op();
      int lat, bc, dones;
      logic [2*W-1:0] of;
      a = 4'd7; b = 4'd15; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      total_cnt++;
      if (op !== 8'd0) $display("FAIL mid_reset_op: got %0d expected 0", op); else pass_cnt++;
      total_cnt++;
      if (busy !== 1'b0) $display("FAIL mid_reset_busy: got %b expected 0", busy); else pass_cnt++;
      rst_n = 1'b1;
      dones = 0;
      for (int i = 0; i < W + 2; i++) begin
         @(negedge clk);
         if (done) dones++;
      end
      total_cnt++;
      if (dones !== 0) $display("FAIL mid_reset_no_done: got %0d expected 0", dones); else pass_cnt++;
      run_op(4'd2, 4'd3, lat, bc, of);
      total_cnt++;
      if (op !== 8'd6) $display("FAIL post_reset_op: got %0d expected 6", op); else pass_cnt++;
      @(negedge clk);
   endtask

   task automatic test_early_term();
      int lat, bc;
      logic [2*W-1:0] of;
      run_op(4'd5, 4'd1, lat, bc, of);
      total_cnt++;
      if (lat !== exp_lat(4'd1)) $display("FAIL b1_latency: got %0d expected %0d", lat, exp_lat(4'd1)); else pass_cnt++;
      total_cnt++;
      if (op !== 8'd5) $display("FAIL b1_op: got %0d expected 5", op); else pass_cnt++;
      @(negedge clk);
      run_op(4'd3, 4'd4, lat, bc, of);
      total_cnt++;
      if (lat !== exp_lat(4'd4)) $display("FAIL b4_latency: got %0d expected %0d", lat, exp_lat(4'd4)); else pass_cnt++;
      total_cnt++;
      if (op !== 8'd12) $display("FAIL b4_op: got %0d expected 12", op); else pass_cnt++;
      @(negedge clk);
      run_op(4'd11, 4'd0, lat, bc, of);
      total_cnt++;
      if (lat !== exp_lat(4'd0)) $display("FAIL b0_latency: got %0d expected %0d", lat, exp_lat(4'd0)); else pass_cnt++;
      total_cnt++;
      if (op !== 8'd0) $display("FAIL b0_op: got %0d expected 0", op); else pass_cnt++;
      @(negedge clk);
   endtask

   initial begin
      @(negedge clk);
      test_reset();
      test_basic();
      test_back_to_back();
      test_extremes();
      test_start_mid_run();
      test_start_in_done_cycle();
      test_continuous_start();
      test_reset_mid_op();
      test_early_term();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule : tb_seq_mul
